// File: rtl/pcs_loopback_pattern_checker_if.sv
// rtl/pcs_loopback_pattern_checker_if.sv - pattern stream toward PCS TX and looped-back stream from PCS RX
interface pcs_loopback_pattern_checker_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] gen_data;
  logic                  gen_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;

  // master: the checker (drives the pattern, receives the loopback)
  modport master (
    output gen_data,
    output gen_valid,
    input  rx_data,
    input  rx_valid
  );

  // slave: the PCS / loopback path
  modport slave (
    input  gen_data,
    input  gen_valid,
    output rx_data,
    output rx_valid
  );
endinterface

// File: rtl/pcs_loopback_pattern_checker.sv
// rtl/pcs_loopback_pattern_checker.sv - PRBS31 generator and self-aligning loopback checker (option: PATTERN_CHECKER_BIT_ERR_EN)
module pcs_loopback_pattern_checker #(
  parameter int          DATA_WIDTH    = 64,
  parameter logic [30:0] SEED          = 31'h0000_0001,
  parameter int          MAX_LATENCY   = 16,
  parameter int          LOCK_THRESH   = 8,
  parameter int          UNLOCK_THRESH = 4,
  parameter int          ERR_CNT_WIDTH = 16,
  localparam int         LAT_W         = $clog2(MAX_LATENCY) + 1
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst,
  input  logic                     cfg_enable,
  input  logic                     clear_counters,
  pcs_loopback_pattern_checker_if.master lb,
  output logic                     pattern_lock,
  output logic [LAT_W-1:0]         latency,
  output logic                     word_error,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic [ERR_CNT_WIDTH-1:0] lock_loss_count
`ifdef PATTERN_CHECKER_BIT_ERR_EN
  ,
  output logic [ERR_CNT_WIDTH-1:0] bit_error_count
`endif
);

  localparam logic [30:0] SEED_EFF = (SEED == 31'd0) ? 31'h7FFF_FFFF : SEED;
  localparam int          RUN_W    = 8;
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  logic [30:0]            prbs_q;
  logic [30:0]            prbs_next;
  logic [DATA_WIDTH-1:0]  word_next;
  logic                   gen_valid_q;
  logic [DATA_WIDTH-1:0]  hist_q [MAX_LATENCY];
  logic [DATA_WIDTH-1:0]  expected;
  logic                   match;

  state_t                 state_q, state_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic [RUN_W-1:0]       match_run_q, match_run_d;
  logic [RUN_W-1:0]       mism_run_q, mism_run_d;
  logic                   word_error_q, word_error_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] loss_cnt_q, loss_cnt_d;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Unroll DATA_WIDTH steps of the x^31+x^28+1 LFSR; the first bit produced lands in bit 0
  always_comb begin
    prbs_next = prbs_q;
    word_next = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      word_next[i] = prbs_next[30] ^ prbs_next[27];
      prbs_next    = {prbs_next[29:0], word_next[i]};
    end
  end

  // Generator and history: hist_q[0] is the word on gen_data, older words shift up on each new word
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      prbs_q      <= SEED_EFF;
      gen_valid_q <= 1'b0;
      for (int k = 0; k < MAX_LATENCY; k++) hist_q[k] <= '0;
    end else begin
      gen_valid_q <= cfg_enable;
      if (cfg_enable) begin
        prbs_q    <= prbs_next;
        hist_q[0] <= word_next;
        for (int k = 1; k < MAX_LATENCY; k++) hist_q[k] <= hist_q[k-1];
      end
    end
  end

  // Select the history word for the current latency candidate
  always_comb begin
    expected = '0;
    for (int k = 0; k < MAX_LATENCY; k++) begin
      if (lat_q == LAT_W'(k)) expected = hist_q[k];
    end
  end

  assign match = (lb.rx_data == expected);

`ifdef PATTERN_CHECKER_BIT_ERR_EN
  localparam int BSUM_W = ERR_CNT_WIDTH + 9;

  logic [ERR_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]               bit_pc;
  logic [BSUM_W-1:0]        bit_sum;

  function automatic logic [7:0] popcount(input logic [DATA_WIDTH-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < DATA_WIDTH; i++) c = c + {7'd0, v[i]};
    return c;
  endfunction

  assign bit_pc  = popcount(lb.rx_data ^ expected);
  assign bit_sum = BSUM_W'(bit_cnt_q) + BSUM_W'(bit_pc);
`endif

  // Search/lock state machine, error pulse and saturating counters
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    match_run_d  = match_run_q;
    mism_run_d   = mism_run_q;
    word_error_d = 1'b0;
    err_cnt_d    = err_cnt_q;
    loss_cnt_d   = loss_cnt_q;
`ifdef PATTERN_CHECKER_BIT_ERR_EN
    bit_cnt_d    = bit_cnt_q;
`endif
    if (!cfg_enable) begin
      state_d     = ST_SEARCH;
      lat_d       = '0;
      match_run_d = '0;
      mism_run_d  = '0;
    end else if (lb.rx_valid) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (match) begin
            if (match_run_q == RUN_W'(LOCK_THRESH - 1)) begin
              state_d     = ST_LOCKED;
              match_run_d = '0;
            end else begin
              match_run_d = match_run_q + 1'b1;
            end
          end else begin
            match_run_d = '0;
            lat_d       = (lat_q == LAT_W'(MAX_LATENCY - 1)) ? '0 : lat_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            mism_run_d = '0;
          end else begin
            word_error_d = 1'b1;
            err_cnt_d    = sat_inc(err_cnt_q);
`ifdef PATTERN_CHECKER_BIT_ERR_EN
            bit_cnt_d    = (bit_sum > BSUM_W'(CNT_MAX)) ? CNT_MAX : bit_sum[ERR_CNT_WIDTH-1:0];
`endif
            if (mism_run_q == RUN_W'(UNLOCK_THRESH - 1)) begin
              state_d     = ST_SEARCH;
              mism_run_d  = '0;
              match_run_d = '0;
              loss_cnt_d  = sat_inc(loss_cnt_q);
            end else begin
              mism_run_d = mism_run_q + 1'b1;
            end
          end
        end
      endcase
    end
    if (clear_counters) begin
      err_cnt_d  = '0;
      loss_cnt_d = '0;
`ifdef PATTERN_CHECKER_BIT_ERR_EN
      bit_cnt_d  = '0;
`endif
    end
  end

  // Checker state register
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q      <= ST_SEARCH;
      lat_q        <= '0;
      match_run_q  <= '0;
      mism_run_q   <= '0;
      word_error_q <= 1'b0;
      err_cnt_q    <= '0;
      loss_cnt_q   <= '0;
`ifdef PATTERN_CHECKER_BIT_ERR_EN
      bit_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      match_run_q  <= match_run_d;
      mism_run_q   <= mism_run_d;
      word_error_q <= word_error_d;
      err_cnt_q    <= err_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
`ifdef PATTERN_CHECKER_BIT_ERR_EN
      bit_cnt_q    <= bit_cnt_d;
`endif
    end
  end

  assign lb.gen_data      = hist_q[0];
  assign lb.gen_valid     = gen_valid_q;
  assign pattern_lock     = (state_q == ST_LOCKED);
  assign latency          = lat_q;
  assign word_error       = word_error_q;
  assign error_count      = err_cnt_q;
  assign lock_loss_count  = loss_cnt_q;
`ifdef PATTERN_CHECKER_BIT_ERR_EN
  assign bit_error_count  = bit_cnt_q;
`endif

endmodule

// File: tb/tb_pcs_loopback_pattern_checker.sv
// tb/tb_pcs_loopback_pattern_checker.sv - randomized loopback bench with behavioural reference model
module tb_pcs_loopback_pattern_checker;
  localparam int DW     = 64;
  localparam int MAXL   = 16;
  localparam int LOCK   = 8;
  localparam int UNLOCK = 4;
  localparam int ERRW   = 4;
  localparam int LATW   = 5;
  localparam int ERRMAX = (1 << ERRW) - 1;

  logic            clk = 1'b0;
  logic            rx_rst = 1'b1;
  logic            cfg_enable = 1'b0;
  logic            clear_counters = 1'b0;
  logic            pattern_lock;
  logic [LATW-1:0] latency;
  logic            word_error;
  logic [ERRW-1:0] error_count;
  logic [ERRW-1:0] lock_loss_count;
`ifdef PATTERN_CHECKER_BIT_ERR_EN
  logic [ERRW-1:0] bit_error_count;
`endif

  pcs_loopback_pattern_checker_if #(.DATA_WIDTH(DW)) lb_if ();

  pcs_loopback_pattern_checker #(
    .DATA_WIDTH(DW), .SEED(31'h0000_0001), .MAX_LATENCY(MAXL),
    .LOCK_THRESH(LOCK), .UNLOCK_THRESH(UNLOCK), .ERR_CNT_WIDTH(ERRW)
  ) dut (
    .rx_clk(clk), .rx_rst(rx_rst), .cfg_enable(cfg_enable), .clear_counters(clear_counters),
    .lb(lb_if), .pattern_lock(pattern_lock), .latency(latency), .word_error(word_error),
    .error_count(error_count), .lock_loss_count(lock_loss_count)
`ifdef PATTERN_CHECKER_BIT_ERR_EN
    , .bit_error_count(bit_error_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          pq[$];
  logic [63:0] words[$];
  logic [63:0] m_gen, m_w, m_exp;
  bit          m_gvalid, m_lock, m_werr;
  int          m_lat, m_mrun, m_mmrun, m_err, m_loss, m_berr;
  logic [30:0] seed_v = 31'h0000_0001;

  task automatic m_reset();
    pq.delete();
    for (int i = 30; i >= 0; i--) pq.push_back(seed_v[i]);
    words.delete();
    m_gen = '0; m_gvalid = 0; m_lock = 0; m_werr = 0;
    m_lat = 0; m_mrun = 0; m_mmrun = 0; m_err = 0; m_loss = 0; m_berr = 0;
  endtask

  // Sequence recurrence x[t] = x[t-31] ^ x[t-28]; pq holds the last 31 bits, oldest first
  task automatic m_word(output logic [63:0] w);
    bit n;
    for (int i = 0; i < DW; i++) begin
      n = pq[0] ^ pq[3];
      w[i] = n;
      pq.push_back(n);
      void'(pq.pop_front());
    end
  endtask

  function automatic logic [63:0] m_hist(input int k);
    if (k < words.size()) return words[words.size() - 1 - k];
    return '0;
  endfunction

  always @(posedge clk) begin
    if (rx_rst) begin
      m_reset();
    end else begin
      m_werr = 0;
      if (!cfg_enable) begin
        m_lock = 0; m_lat = 0; m_mrun = 0; m_mmrun = 0;
      end else if (lb_if.rx_valid) begin
        m_exp = m_hist(m_lat);
        if (lb_if.rx_data == m_exp) begin
          if (!m_lock) begin
            m_mrun++;
            if (m_mrun == LOCK) begin m_lock = 1; m_mrun = 0; end
          end else begin
            m_mmrun = 0;
          end
        end else if (!m_lock) begin
          m_mrun = 0;
          m_lat = (m_lat + 1) % MAXL;
        end else begin
          m_werr = 1;
          if (m_err < ERRMAX) m_err++;
          m_berr = m_berr + $countones(lb_if.rx_data ^ m_exp);
          if (m_berr > ERRMAX) m_berr = ERRMAX;
          m_mmrun++;
          if (m_mmrun == UNLOCK) begin
            m_lock = 0; m_mmrun = 0; m_mrun = 0;
            if (m_loss < ERRMAX) m_loss++;
          end
        end
      end
      if (clear_counters) begin m_err = 0; m_loss = 0; m_berr = 0; end
      if (cfg_enable) begin
        m_word(m_w);
        words.push_back(m_w);
        if (words.size() > MAXL) void'(words.pop_front());
        m_gen = m_w;
        m_gvalid = 1;
      end else begin
        m_gvalid = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gen_data", lb_if.gen_data, m_gen);
      chk("gen_valid", {63'd0, lb_if.gen_valid}, {63'd0, m_gvalid});
      chk("pattern_lock", {63'd0, pattern_lock}, {63'd0, m_lock});
      chk("latency", {59'd0, latency}, 64'(m_lat));
      chk("word_error", {63'd0, word_error}, {63'd0, m_werr});
      chk("error_count", {60'd0, error_count}, 64'(m_err));
      chk("lock_loss_count", {60'd0, lock_loss_count}, 64'(m_loss));
`ifdef PATTERN_CHECKER_BIT_ERR_EN
      chk("bit_error_count", {60'd0, bit_error_count}, 64'(m_berr));
`endif
    end
  end

  // ---------------- stimulus ----------------
  logic [64:0] line[$];
  logic [64:0] ent;
  bit          rst_k = 1, cfg_k = 0, clr_k = 0, gap_ph = 0;
  int          dly_k = 6;
  int          gap_mode = 0;
  logic [63:0] flip_k = '0;

  task automatic step();
    bit ok;
    @(negedge clk);
    line.push_back({lb_if.gen_valid, lb_if.gen_data});
    if (line.size() > 40) void'(line.pop_front());
    rx_rst = rst_k;
    cfg_enable = cfg_k;
    clear_counters = clr_k;
    gap_ph = ~gap_ph;
    case (gap_mode)
      1: ok = gap_ph;
      2: ok = ($urandom_range(3) != 0);
      default: ok = 1;
    endcase
    if (line.size() > dly_k) begin
      ent = line[line.size() - 1 - dly_k];
      lb_if.rx_data = ent[63:0] ^ flip_k;
      lb_if.rx_valid = ent[64] & ok;
    end else begin
      lb_if.rx_data = {$urandom, $urandom};
      lb_if.rx_valid = 1'b0;
    end
  endtask

  task automatic wait_lock(input string nm, input int budget);
    int n = 0;
    while (!pattern_lock && n < budget) begin step(); n++; end
    chk(nm, {63'd0, pattern_lock}, 64'd1);
  endtask

  initial begin
    lb_if.rx_data = '0;
    lb_if.rx_valid = 1'b0;
    // reset values
    step(); step();
    chk_en = 1;
    chk("rst gen_valid", {63'd0, lb_if.gen_valid}, 64'd0);
    chk("rst gen_data", lb_if.gen_data, 64'd0);
    chk("rst lock", {63'd0, pattern_lock}, 64'd0);
    chk("rst count", {60'd0, error_count}, 64'd0);
    rst_k = 0;
    step(); step();
    // first PRBS word from SEED=1: bits 27, 30, 55, 61
    line.delete();
    cfg_k = 1;
    step(); step();
    chk("first word", lb_if.gen_data, 64'h2080_0000_4800_0000);
    // direct loopback at delay 6
    wait_lock("lock d6", 40);
    chk("latency d6", {59'd0, latency}, 64'd6);
    repeat (2000) step();
    chk("no errors", {60'd0, error_count}, 64'd0);
    // single corruption
    flip_k = 64'd1; step(); flip_k = '0; step();
    chk("single pulse", {63'd0, word_error}, 64'd1);
    step();
    chk("single count", {60'd0, error_count}, 64'd1);
    chk("single lock", {63'd0, pattern_lock}, 64'd1);
`ifdef PATTERN_CHECKER_BIT_ERR_EN
    chk("single bits", {60'd0, bit_error_count}, 64'd1);
`endif
    // burst of UNLOCK corrupted words
    flip_k = 64'h8000_0000_0000_0001;
    repeat (4) step();
    flip_k = '0; step();
    chk("burst unlock", {63'd0, pattern_lock}, 64'd0);
    chk("burst loss", {60'd0, lock_loss_count}, 64'd1);
    chk("burst count", {60'd0, error_count}, 64'd5);
    repeat (8) step();
    chk("burst relock", {63'd0, pattern_lock}, 64'd1);
    chk("burst latency", {59'd0, latency}, 64'd6);
    // enable drop, then rx_valid on every other cycle
    cfg_k = 0; step(); step();
    chk("disable lock", {63'd0, pattern_lock}, 64'd0);
    chk("disable latency", {59'd0, latency}, 64'd0);
    chk("disable loss", {60'd0, lock_loss_count}, 64'd1);
    cfg_k = 1; gap_mode = 1;
    wait_lock("lock gaps", 200);
    chk("gaps latency", {59'd0, latency}, 64'd6);
    chk("gaps count", {60'd0, error_count}, 64'd5);
    gap_mode = 0;
    // latency 15 then 2 (wraps 15 -> 0)
    dly_k = 15; repeat (6) step();
    wait_lock("lock d15", 100);
    chk("latency d15", {59'd0, latency}, 64'd15);
    dly_k = 2; repeat (6) step();
    wait_lock("lock d2", 100);
    chk("latency d2", {59'd0, latency}, 64'd2);
    chk("loss d2", {60'd0, lock_loss_count}, 64'd3);
    // saturation: 3 bad / 1 good keeps lock while errors pile up
    repeat (8) begin
      flip_k = 64'd4; repeat (3) step();
      flip_k = '0; step();
    end
    step();
    chk("sat count", {60'd0, error_count}, 64'd15);
    chk("sat lock", {63'd0, pattern_lock}, 64'd1);
    flip_k = 64'd2; clr_k = 1; step();
    flip_k = '0; clr_k = 0; step();
    chk("clear wins", {60'd0, error_count}, 64'd0);
    chk("clear loss", {60'd0, lock_loss_count}, 64'd0);
    // randomized phase, model-checked each cycle
    gap_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(199) == 0) dly_k = $urandom_range(15);
      cfg_k = ($urandom_range(99) != 0);
      clr_k = ($urandom_range(63) == 0);
      case ($urandom_range(15))
        0: flip_k = 64'd1 << $urandom_range(63);
        1: flip_k = {$urandom, $urandom};
        default: flip_k = '0;
      endcase
      step();
    end
    flip_k = '0; clr_k = 0; cfg_k = 1;
    // mid-run reset
    rst_k = 1; step(); rst_k = 0; step();
    chk("mid rst gen_valid", {63'd0, lb_if.gen_valid}, 64'd0);
    chk("mid rst gen_data", lb_if.gen_data, 64'd0);
    chk("mid rst lock", {63'd0, pattern_lock}, 64'd0);
    chk("mid rst latency", {59'd0, latency}, 64'd0);
    chk("mid rst loss", {60'd0, lock_loss_count}, 64'd0);
    repeat (20) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
